// File: rtl/waitstate_memory.sv
// waitstate_memory: single-port synchronous RAM behind a req/ready/ack handshake with WAIT wait states.
// Define MEM_PARITY_EN to keep an even-parity bit per word and flag read errors on err.
module waitstate_memory #(
  parameter int    A         = 12,
  parameter int    M         = 16,
  parameter int    WAIT      = 2,
  parameter string INIT_FILE = ""
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         req,
  input  logic         we,
  input  logic [A-1:0] addr,
  input  logic [M-1:0] wdata,
  input  logic         par_inj,
  output logic         ready,
  output logic         ack,
  output logic [M-1:0] rdata,
  output logic         err
);

`ifdef MEM_PARITY_EN
  localparam int W = M + 1;
`else
  localparam int W = M;
`endif

  typedef enum logic {IDLE, BUSY} state_t;

  state_t       state;
  logic [3:0]   cnt;
  logic         we_q;
  logic [A-1:0] addr_q;
  logic [M-1:0] wdata_q;
  logic         par_inj_q;

  logic [W-1:0] mem [2**A];
  logic [W-1:0] wr_word;
  logic [W-1:0] rd_word;
  logic         par_bad;
  logic         do_access;

  assign do_access = (state == BUSY) && (cnt == 4'd0);
  assign rd_word   = mem[addr_q];

`ifdef MEM_PARITY_EN
  // bit M is even parity of the data, deliberately flipped when par_inj was set
  assign wr_word = {(^wdata_q) ^ par_inj_q, wdata_q};
  assign par_bad = (^rd_word[M-1:0]) != rd_word[M];
`else
  logic unused_par_inj;
  assign unused_par_inj = par_inj_q;
  assign wr_word        = wdata_q;
  assign par_bad        = 1'b0;
`endif

  // array has no reset; reset forces IDLE so a pending write never lands
  always_ff @(posedge CLK) begin
    if (do_access && we_q) mem[addr_q] <= wr_word;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      ready     <= 1'b1;
      ack       <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
      cnt       <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      par_inj_q <= 1'b0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            we_q      <= we;
            addr_q    <= addr;
            wdata_q   <= wdata;
            par_inj_q <= par_inj;
            cnt       <= 4'(WAIT);
            ready     <= 1'b0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!we_q) begin
              rdata <= rd_word[M-1:0];
              err   <= par_bad;
            end
            ack   <= 1'b1;
            ready <= 1'b1;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_waitstate_memory.sv
// Bench for waitstate_memory: transaction-level model checked every cycle plus directed literal checks.
// Instance 0 runs WAIT=2, instance 1 runs WAIT=0.
module tb_waitstate_memory;
  localparam int A = 12;
  localparam int M = 16;
`ifdef MEM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic         req_s   [2];
  logic         we_s    [2];
  logic         inj_s   [2];
  logic [A-1:0] addr_s  [2];
  logic [M-1:0] wdata_s [2];
  logic         ready_s [2];
  logic         ack_s   [2];
  logic         err_s   [2];
  logic [M-1:0] rdata_s [2];

  always #5 CLK = ~CLK;

  waitstate_memory #(.A(A), .M(M), .WAIT(2)) u_w2 (
    .CLK(CLK), .RST_N(RST_N), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]),
    .wdata(wdata_s[0]), .par_inj(inj_s[0]), .ready(ready_s[0]), .ack(ack_s[0]),
    .rdata(rdata_s[0]), .err(err_s[0]));

  waitstate_memory #(.A(A), .M(M), .WAIT(0)) u_w0 (
    .CLK(CLK), .RST_N(RST_N), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]),
    .wdata(wdata_s[1]), .par_inj(inj_s[1]), .ready(ready_s[1]), .ack(ack_s[1]),
    .rdata(rdata_s[1]), .err(err_s[1]));

  function automatic int wait_of(int k);
    return (k == 0) ? 2 : 0;
  endfunction

  // transaction model: an accepted request completes WAIT+1 edges later
  bit          busy_m  [2];
  int          done_m  [2];
  bit          pwe     [2];
  logic [11:0] paddr   [2];
  logic [15:0] pwd     [2];
  bit          pinj    [2];
  logic [15:0] mdata   [2][4096];
  bit          mbad    [2][4096];
  logic        exp_ready [2];
  logic        exp_ack   [2];
  logic        exp_err   [2];
  logic [15:0] exp_rdata [2];
  int          acc_n   [2];
  int          acc_cyc [2];
  int          ack_cnt [2];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      busy_m[k] = 0; exp_ready[k] = 1'b1; exp_ack[k] = 1'b0; exp_err[k] = 1'b0;
      exp_rdata[k] = '0; acc_n[k] = 0; acc_cyc[k] = 0; done_m[k] = 0;
    end
    forever begin
      @(posedge CLK or negedge RST_N);
      if (!RST_N) begin
        for (int k = 0; k < 2; k++) begin
          busy_m[k] = 0; exp_ready[k] = 1'b1; exp_ack[k] = 1'b0;
          exp_err[k] = 1'b0; exp_rdata[k] = '0;
        end
      end else begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
          exp_ack[k] = 1'b0;
          exp_err[k] = 1'b0;
          if (busy_m[k]) begin
            if (cyc == done_m[k]) begin
              if (pwe[k]) begin
                mdata[k][paddr[k]] = pwd[k];
                mbad[k][paddr[k]]  = pinj[k];
              end else begin
                exp_rdata[k] = mdata[k][paddr[k]];
                exp_err[k]   = PAR & mbad[k][paddr[k]];
              end
              exp_ack[k]   = 1'b1;
              exp_ready[k] = 1'b1;
              busy_m[k]    = 0;
            end
          end else if (req_s[k] === 1'b1) begin
            busy_m[k]    = 1;
            done_m[k]    = cyc + wait_of(k) + 1;
            pwe[k]       = we_s[k];
            paddr[k]     = addr_s[k];
            pwd[k]       = wdata_s[k];
            pinj[k]      = inj_s[k];
            exp_ready[k] = 1'b0;
            acc_n[k]++;
            acc_cyc[k]   = cyc;
          end
        end
      end
    end
  end

  initial begin
    ack_cnt[0] = 0;
    ack_cnt[1] = 0;
    forever begin
      @(negedge CLK);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("cmp_ready[%0d]", k), ready_s[k], exp_ready[k]);
        chk($sformatf("cmp_ack[%0d]", k), ack_s[k], exp_ack[k]);
        chk($sformatf("cmp_rdata[%0d]", k), rdata_s[k], exp_rdata[k]);
        chk($sformatf("cmp_err[%0d]", k), err_s[k], exp_err[k]);
        if (ack_s[k] === 1'b1) ack_cnt[k]++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_accept(int k, output int c);
    int  n0;
    bit  got;
    n0  = acc_n[k];
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(posedge CLK);
      #1;
      if (acc_n[k] != n0) got = 1;
    end
    chk("accept_timeout", got, 1);
    c = acc_cyc[k];
  endtask

  // called at a falling edge; returns at the falling edge where ack was seen
  task automatic op(int k, bit w, logic [11:0] a, logic [15:0] d, bit inj, int lat,
                    output logic [15:0] rd, output logic er);
    int c;
    int n;
    bit seen;
    rd = '0;
    er = 1'b0;
    req_s[k] = 1'b1; we_s[k] = w; addr_s[k] = a; wdata_s[k] = d; inj_s[k] = inj;
    wait_accept(k, c);
    req_s[k] = 1'b0;
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(negedge CLK);
      n++;
      if (ack_s[k] === 1'b1) begin
        seen = 1;
        rd = rdata_s[k];
        er = err_s[k];
        if (lat > 0) chk("ready_at_ack", ready_s[k], 1);
      end else if (lat > 0) begin
        chk("ready_low", ready_s[k], 0);
      end
    end
    chk("ack_seen", seen, 1);
    if (lat > 0) chk("latency", n - 1, lat);
  endtask

  logic [15:0] rd;
  logic        er;
  int          c, prev_c, a0;

  initial begin
    for (int k = 0; k < 2; k++) begin
      req_s[k] = 0; we_s[k] = 0; inj_s[k] = 0; addr_s[k] = '0; wdata_s[k] = '0;
    end
    repeat (3) @(negedge CLK);
    #2 RST_N = 1'b1;
    @(negedge CLK);
    chk("rst_ready", ready_s[0], 1);
    chk("rst_ack", ack_s[0], 0);
    chk("rst_rdata", rdata_s[0], 16'h0000);
    chk("rst_err", err_s[0], 0);

    // WAIT=2 write then read back
    op(0, 1'b1, 12'h12C, 16'h11F4, 1'b0, 3, rd, er);
    op(0, 1'b0, 12'h12C, 16'h0000, 1'b0, 3, rd, er);
    chk("t2_rdata", rd, 16'h11F4);

    // asynchronous reset in mid-cycle
    @(posedge CLK);
    #3 RST_N = 1'b0;
    #1;
    chk("t1_ready", ready_s[0], 1);
    chk("t1_ack", ack_s[0], 0);
    chk("t1_rdata", rdata_s[0], 16'h0000);
    chk("t1_err", err_s[0], 0);
    @(negedge CLK);
    #2 RST_N = 1'b1;
    @(negedge CLK);

    // WAIT=0 with req held high: alternating W,R,W,R
    a0 = ack_cnt[1];
    prev_c = 0;
    req_s[1] = 1'b1; we_s[1] = 1'b1; addr_s[1] = 12'h1F4; wdata_s[1] = 16'h1010; inj_s[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_accept(1, c);
      if (i > 0) chk("t3_gap", c - prev_c, 2);
      prev_c = c;
      we_s[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
    end
    req_s[1] = 1'b0;
    repeat (3) @(negedge CLK);
    chk("t3_acks", ack_cnt[1] - a0, 4);
    chk("t3_rdata", rdata_s[1], 16'h1010);

    // req while busy is ignored
    op(0, 1'b1, 12'h300, 16'h3333, 1'b0, 3, rd, er);
    req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 12'h150; wdata_s[0] = 16'h5A5A;
    wait_accept(0, c);
    req_s[0] = 1'b0;
    @(negedge CLK);
    req_s[0] = 1'b1; addr_s[0] = 12'h300; wdata_s[0] = 16'hFFFF;
    @(negedge CLK);
    req_s[0] = 1'b0;
    repeat (3) @(negedge CLK);
    op(0, 1'b0, 12'h300, 16'h0000, 1'b0, 3, rd, er);
    chk("t4_untouched", rd, 16'h3333);
    op(0, 1'b0, 12'h150, 16'h0000, 1'b0, 3, rd, er);
    chk("t4_latched", rd, 16'h5A5A);

    // reset abandons a pending write
    op(0, 1'b1, 12'h400, 16'hBEEF, 1'b0, 3, rd, er);
    a0 = ack_cnt[0];
    req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 12'h400; wdata_s[0] = 16'h4139;
    wait_accept(0, c);
    req_s[0] = 1'b0;
    @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("t5_ready", ready_s[0], 1);
    chk("t5_ack", ack_s[0], 0);
    @(negedge CLK);
    #2 RST_N = 1'b1;
    repeat (4) @(negedge CLK);
    chk("t5_no_ack", ack_cnt[0] - a0, 0);
    op(0, 1'b0, 12'h400, 16'h0000, 1'b0, 3, rd, er);
    chk("t5_rdata", rd, 16'hBEEF);

    // parity injection
    op(0, 1'b1, 12'h201, 16'h025E, 1'b1, 3, rd, er);
    op(0, 1'b0, 12'h201, 16'h0000, 1'b0, 3, rd, er);
    chk("t6_rdata_inj", rd, 16'h025E);
    chk("t6_err_inj", er, PAR);
    op(0, 1'b1, 12'h201, 16'h025E, 1'b0, 3, rd, er);
    op(0, 1'b0, 12'h201, 16'h0000, 1'b0, 3, rd, er);
    chk("t6_err_clean", er, 0);

    repeat (2) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
